// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes A - B - borrowin one bit per clock, LSB first.
// Optional signed overflow flag enabled by defining SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor #(
   parameter int NUMBITS = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [NUMBITS-1:0] A,
   input  logic [NUMBITS-1:0] B,
   input  logic               borrowin,
   output logic               busy,
   output logic               done,
   output logic [NUMBITS-1:0] result,
   output logic               borrowout,
   output logic               overflow
);

   localparam int CW = $clog2(NUMBITS);
   localparam logic [CW-1:0] LAST = CW'(NUMBITS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t state_q, state_d;

   logic [NUMBITS-1:0] a_reg, b_reg, shreg;
   logic [CW-1:0]      cnt;
   logic               bw_reg;
   logic               bit_a, bit_b, diff_bit, bw_next, last_bit;
   logic [NUMBITS-1:0] shreg_next;

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: if (start) state_d = RUN;
         RUN: begin
            busy = 1'b1;
            if (cnt == LAST) state_d = DONE;
         end
         DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Latched operands stay untouched; the counter selects the bit to process.
   assign bit_a      = a_reg[cnt];
   assign bit_b      = b_reg[cnt];
   assign diff_bit   = bit_a ^ bit_b ^ bw_reg;
   assign bw_next    = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & bw_reg);
   assign shreg_next = {diff_bit, shreg[NUMBITS-1:1]};
   assign last_bit   = (state_q == RUN) && (cnt == LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         a_reg     <= '0;
         b_reg     <= '0;
         bw_reg    <= 1'b0;
         cnt       <= '0;
         shreg     <= '0;
         result    <= '0;
         borrowout <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  a_reg  <= A;
                  b_reg  <= B;
                  bw_reg <= borrowin;
                  cnt    <= '0;
                  shreg  <= '0;
               end
            end
            RUN: begin
               shreg  <= shreg_next;
               bw_reg <= bw_next;
               cnt    <= last_bit ? '0 : cnt + 1'b1;
               if (last_bit) begin
                  result    <= shreg_next;
                  borrowout <= bw_next;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef SERIAL_SUB_OVERFLOW_EN
   always_ff @(posedge clk) begin
      if (reset)
         overflow <= 1'b0;
      else if (last_bit)
         overflow <= (a_reg[NUMBITS-1] != b_reg[NUMBITS-1]) &&
                     (diff_bit != a_reg[NUMBITS-1]);
   end
`else
   assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (NUMBITS=8).
module tb_serial_subtractor;

   localparam int NUMBITS = 8;
`ifdef SERIAL_SUB_OVERFLOW_EN
   localparam logic OV_EN = 1'b1;
`else
   localparam logic OV_EN = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               reset = 1'b0;
   logic               start = 1'b0;
   logic [NUMBITS-1:0] A = '0;
   logic [NUMBITS-1:0] B = '0;
   logic               borrowin = 1'b0;
   logic               busy, done, borrowout, overflow;
   logic [NUMBITS-1:0] result;

   int checks = 0;
   int errors = 0;
   logic [NUMBITS-1:0] prev_result = '0;

   serial_subtractor #(.NUMBITS(NUMBITS)) dut (
      .clk(clk), .reset(reset), .start(start), .A(A), .B(B),
      .borrowin(borrowin), .busy(busy), .done(done), .result(result),
      .borrowout(borrowout), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Launches one operation and checks latency, busy length, hold behaviour and outputs.
   task automatic applyStimulus(input string tag, input logic [7:0] a, input logic [7:0] b,
                                input logic bi, input logic [7:0] exp_res,
                                input logic exp_bo, input logic exp_ov);
      int k;
      int busy_cycles;
      A = a; B = b; borrowin = bi; start = 1'b1;
      tick();
      start = 1'b0; A = 8'hA5; B = 8'h5A; borrowin = ~bi;
      busy_cycles = busy ? 1 : 0;
      k = 0;
      while (k < 20) begin
         tick();
         k++;
         if (busy) busy_cycles++;
         if (k == 3) checkOutput({tag, "_hold_prev"}, result, prev_result);
         if (done) break;
      end
      checkOutput({tag, "_latency"}, k, NUMBITS);
      checkOutput({tag, "_result"}, result, exp_res);
      checkOutput({tag, "_borrowout"}, borrowout, exp_bo);
      checkOutput({tag, "_overflow"}, overflow, exp_ov);
      tick();
      checkOutput({tag, "_done_width"}, done, 0);
      checkOutput({tag, "_busy_len"}, busy_cycles, NUMBITS + 1);
      checkOutput({tag, "_idle"}, busy, 0);
      checkOutput({tag, "_result_held"}, result, exp_res);
      prev_result = exp_res;
   endtask

   initial begin
      int pulses;
      $display("[TB] start, overflow feature = %0d", OV_EN);

      reset = 1'b1; start = 1'b1; A = 8'hFF; B = 8'h01;
      tick(); tick();
      start = 1'b0;
      reset = 1'b0;
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_result", result, 0);
      checkOutput("reset_borrowout", borrowout, 0);
      checkOutput("reset_overflow", overflow, 0);
      tick();
      checkOutput("reset_prio_start", busy, 0);

      applyStimulus("sub_05_03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
      applyStimulus("sub_00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
      applyStimulus("sub_80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, OV_EN);
      applyStimulus("sub_10_10_bi", 8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0);
      applyStimulus("sub_7F_FF", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, OV_EN);

      // Second start during RUN must be ignored.
      A = 8'h20; B = 8'h01; borrowin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      pulses = 0;
      for (int i = 1; i <= 25; i++) begin
         if (i == 3) begin A = 8'hFF; B = 8'hFF; start = 1'b1; end
         tick();
         if (i == 3) start = 1'b0;
         if (done) pulses++;
      end
      checkOutput("ignore_start_pulses", pulses, 1);
      checkOutput("ignore_start_result", result, 8'h1F);
      checkOutput("ignore_start_borrowout", borrowout, 0);
      prev_result = 8'h1F;

      // Reset in RUN cycle 4 aborts the operation.
      A = 8'h33; B = 8'h11; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_done", done, 0);
      checkOutput("abort_result", result, 0);
      pulses = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (done || busy) pulses++;
      end
      checkOutput("abort_no_done", pulses, 0);
      prev_result = 8'h00;
      applyStimulus("after_abort", 8'h33, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
